fetch_sequencer: RTL and testbench

Instruction fetch and sequencing controller for the 16-bit bus processor. Reads instruction words from a synchronous ROM, prefetches the immediate word for `mvi`, and drives `DIN`/`Run` into the processor. It waits for the processor's `Done`, counts retired instructions, and halts on end-of-program or on a watchdog timeout. It sits between the program ROM and the processor's `DIN`/`Run`/`Done` pins.

---
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 tb/tb_fetch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing controller: reads a synchronous ROM, prefetches mvi immediates,
// drives DIN/Run into the processor and halts on end-of-program or watchdog. Option: FETCH_WRAP_EN.
module fetch_sequencer #(
  parameter int          ADDR_W     = 5,
  parameter int unsigned START_ADDR = 0,
  parameter int          TIMEOUT    = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [15:0]       MemData,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Halt,
  output logic              Error,
  output logic [15:0]       InstrCount
);

`ifdef FETCH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [2:0]        OP_MVI  = 3'b001;
  localparam logic [7:0]        WD_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(START_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH_IMM, S_CAPT_IMM, S_ISSUE, S_EXEC, S_HALTED
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir_q, imm_q, din_q, cnt_q;
  logic [7:0]        wdog_q;
  logic              run_q, halt_q, err_q, end_q;

  logic pc_last, mem_mvi, ir_mvi;

  assign pc_last = (pc_q == '1);
  assign mem_mvi = (MemData[15:13] == OP_MVI);
  assign ir_mvi  = (ir_q[15:13] == OP_MVI);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      ir_q    <= '0;
      imm_q   <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      wdog_q  <= '0;
      run_q   <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (Enable) state_q <= S_FETCH;
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          ir_q <= MemData;
          if (mem_mvi) begin
            // Without wrap the immediate would lie past the program end.
            if (!WRAP && pc_last) begin
              err_q   <= 1'b1;
              halt_q  <= 1'b1;
              state_q <= S_HALTED;
            end else begin
              pc_q    <= pc_q + ADDR_W'(1);
              state_q <= S_FETCH_IMM;
            end
          end else begin
            pc_q    <= pc_q + ADDR_W'(1);
            end_q   <= end_q | (!WRAP && pc_last);
            din_q   <= MemData;
            run_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_FETCH_IMM: state_q <= S_CAPT_IMM;
        S_CAPT_IMM: begin
          imm_q   <= MemData;
          pc_q    <= pc_q + ADDR_W'(1);
          end_q   <= end_q | (!WRAP && pc_last);
          din_q   <= ir_q;
          run_q   <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          wdog_q  <= '0;
          din_q   <= ir_mvi ? imm_q : ir_q;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (Done) begin
            cnt_q <= cnt_q + 16'd1;
            run_q <= 1'b0;
            din_q <= '0;
            if (end_q) begin
              halt_q  <= 1'b1;
              state_q <= S_HALTED;
            end else if (Enable) begin
              state_q <= S_FETCH;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (wdog_q == WD_LAST) begin
            err_q   <= 1'b1;
            halt_q  <= 1'b1;
            run_q   <= 1'b0;
            din_q   <= '0;
            state_q <= S_HALTED;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign MemAddr    = pc_q;
  assign DIN        = din_q;
  assign Run        = run_q;
  assign Halt       = halt_q;
  assign Error      = err_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a program-level model predicts the issued instruction stream.
module tb_fetch_sequencer;
  localparam int AW = 3;
  localparam int N  = 1 << AW;
  localparam int TO = 15;
`ifdef FETCH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    logic [15:0]   ir;
    logic [15:0]   ex;
    logic [AW-1:0] addr;
  } exp_t;

  logic          Clock = 1'b0;
  logic          Reset, Enable, Done;
  logic [AW-1:0] MemAddr;
  logic [15:0]   MemData, DIN, InstrCount;
  logic          Run, Halt, Error;
  logic [15:0]   rom [N];

  exp_t        sb[$];
  int unsigned addr_hist[$];
  int checks = 0;
  int errors = 0;
  int n_issued = 0;
  int dmode = 0;

  fetch_sequencer #(.ADDR_W(AW), .START_ADDR(0), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .MemAddr(MemAddr), .MemData(MemData),
    .DIN(DIN), .Run(Run), .Done(Done), .Halt(Halt), .Error(Error), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) MemData <= rom[MemAddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Processor stand-in: answers each Run with a Done pulse after a random number of EXEC cycles.
  initial begin
    bit prev = 1'b0;
    int d;
    Done = 1'b0;
    forever begin
      @(negedge Clock);
      if (Run && !prev) begin
        if (dmode == 1) begin
          Done = 1'b1;
          @(negedge Clock);
          Done = 1'b0;
        end else begin
          d = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(1, 3);
          repeat (d) @(negedge Clock);
          Done = 1'b1;
          @(negedge Clock);
          Done = 1'b0;
        end
      end
      prev = Run;
    end
  end

  // Monitor: pops one expectation per Run rising edge and checks DIN through EXEC.
  initial begin
    bit   mon_prev = 1'b0;
    bit   in_exec  = 1'b0;
    exp_t cur;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        mon_prev = 1'b0;
        in_exec  = 1'b0;
      end else begin
        if (Run && !mon_prev) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: DIN %0h with empty scoreboard at %0t", DIN, $time);
            in_exec = 1'b0;
          end else begin
            cur = sb.pop_front();
            n_issued++;
            check("issue_din", 32'(DIN), 32'(cur.ir));
            check("issue_pc", 32'(MemAddr), 32'(cur.addr));
            in_exec = 1'b1;
          end
        end else if (Run && in_exec) begin
          check("exec_din", 32'(DIN), 32'(cur.ex));
        end else if (!Run) begin
          check("idle_din", 32'(DIN), 32'd0);
          in_exec = 1'b0;
        end
        mon_prev = Run;
      end
    end
  end

  function automatic logic [15:0] rand_word(input bit allow_mvi);
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
    if (allow_mvi && $urandom_range(0, 2) == 0) op = 3'b001;
    else if (op == 3'b001) op = 3'b000;
    return {op, 13'($urandom)};
  endfunction

  // Walks the program from address 0 for at most L instructions; term 0=none, 1=end, 2=fault.
  task automatic build_model(input int L, output int len, output int term);
    int          pc;
    bit          crossed;
    exp_t        e;
    logic [15:0] w;
    pc = 0; len = 0; term = 0;
    addr_hist.delete();
    while (len < L) begin
      w = rom[pc];
      e.ir = w;
      if (w[15:13] == 3'b001) begin
        if (!WRAP && pc == N - 1) begin
          term = 2;
          break;
        end
        e.ex = rom[(pc + 1) % N];
        crossed = (pc + 2 >= N);
        pc = (pc + 2) % N;
      end else begin
        e.ex = w;
        crossed = (pc + 1 >= N);
        pc = (pc + 1) % N;
      end
      e.addr = AW'(pc);
      sb.push_back(e);
      addr_hist.push_back(pc);
      len++;
      if (!WRAP && crossed) begin
        term = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Enable = 1'b0;
    sb.delete();
    n_issued = 0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic run_until(input int target);
    int cyc = 0;
    while (cyc < 3000) begin
      @(negedge Clock);
      cyc++;
      if (n_issued >= target) Enable = 1'b0;
      if (int'(InstrCount) == target && !Run) break;
    end
    if (cyc >= 3000) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: count %0d required %0d", InstrCount, target);
    end
  endtask

  task automatic wait_halt();
    int cyc = 0;
    while (!Halt && cyc < 3000) begin
      @(negedge Clock);
      cyc++;
    end
    check("halt_reached", 32'(Halt), 32'd1);
  endtask

  task automatic run_prog(input int L);
    int len, term;
    do_reset();
    build_model(L, len, term);
    Enable = 1'b1;
    if (term == 0) begin
      run_until(L - 1);
      repeat (4) @(negedge Clock);
      check("idle_run", 32'(Run), 32'd0);
      check("idle_pc", 32'(MemAddr), addr_hist[L-2]);
      check("idle_count", 32'(InstrCount), 32'(L - 1));
      Enable = 1'b1;
      run_until(L);
      check("final_count", 32'(InstrCount), 32'(L));
      check("final_halt", 32'(Halt), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);
    end else begin
      wait_halt();
      check("halt_error", 32'(Error), 32'(term == 2));
      check("halt_count", 32'(InstrCount), 32'(len));
      check("halt_run", 32'(Run), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);
      repeat (3) @(negedge Clock);
      check("halt_sticky", 32'(Halt), 32'd1);
    end
  endtask

  initial begin
    int len, term, cnt, cyc;
    Reset = 1'b1;
    Enable = 1'b0;
    for (int i = 0; i < N; i++) rom[i] = 16'h0040;
    #1;
    check("rst_addr", 32'(MemAddr), 32'd0);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_run", 32'(Run), 32'd0);
    check("rst_halt", 32'(Halt), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_count", 32'(InstrCount), 32'd0);

    // mv, then mvi with immediate, then mv
    rom[1] = 16'h2000;
    rom[2] = 16'h1234;
    run_prog(3);

    // straight-line program: end of ROM (or wrap)
    for (int i = 0; i < N; i++) rom[i] = rand_word(1'b0);
    run_prog(N + 3);

    // mvi sitting at the last address
    rom[N-1] = 16'h2abc;
    run_prog(N + 3);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) rom[i] = rand_word(1'b1);
      run_prog(int'($urandom_range(2, 12)));
    end

    // watchdog: Done only pulsed during ISSUE, where it must be ignored
    for (int i = 0; i < N; i++) rom[i] = rand_word(1'b0);
    do_reset();
    build_model(1, len, term);
    dmode = 1;
    Enable = 1'b1;
    cyc = 0;
    while (!Run && cyc < 100) begin
      @(negedge Clock);
      cyc++;
    end
    cnt = 0;
    while (!Halt && cnt < 100) begin
      @(negedge Clock);
      cnt++;
    end
    check("wd_cycles", 32'(cnt), 32'(TO + 1));
    check("wd_error", 32'(Error), 32'd1);
    check("wd_run", 32'(Run), 32'd0);
    check("wd_count", 32'(InstrCount), 32'd0);
    dmode = 0;

    // reset while capturing an mvi immediate
    for (int i = 0; i < N; i++) rom[i] = 16'h0040;
    rom[1] = 16'h2000;
    rom[2] = 16'h1234;
    do_reset();
    build_model(1, len, term);
    Enable = 1'b1;
    cyc = 0;
    while (InstrCount != 16'd1 && cyc < 200) begin
      @(negedge Clock);
      cyc++;
    end
    check("pre_rst_count", 32'(InstrCount), 32'd1);
    repeat (3) @(posedge Clock);
    #1;
    check("capt_pc", 32'(MemAddr), 32'd2);
    check("capt_run", 32'(Run), 32'd0);
    #1 Reset = 1'b1;
    #1;
    check("async_run", 32'(Run), 32'd0);
    check("async_addr", 32'(MemAddr), 32'd0);
    check("async_count", 32'(InstrCount), 32'd0);
    check("async_din", 32'(DIN), 32'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
